// File: rtl/seq_divider.sv
// Iterative signed divider: one restoring step per clock on operand magnitudes,
// then a single sign-fix cycle. Quotient truncates toward zero; remainder follows dividend sign.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             active,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic             q_sign;
  logic             r_sign;
  logic             zero_div;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_src;

  // Magnitudes are unsigned, so the most-negative value maps onto itself and still divides correctly.
  assign a_mag   = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag   = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign shifted = {part_rem, dvd_mag[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_mag};
  assign rem_src = zero_div ? dvd_mag : part_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    active     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (B == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          next_state = FIX;
        end
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      part_rem    <= '0;
      dvd_mag     <= '0;
      dsr_mag     <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_mag  <= a_mag;
            dsr_mag  <= b_mag;
            part_rem <= '0;
            q_sign   <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sign   <= A[WIDTH-1];
            zero_div <= (B == '0);
            count    <= CW'(WIDTH);
          end
        end
        RUN: begin
          // A non-negative trial difference means the divisor fits; keep it and emit a 1.
          if (!trial[WIDTH]) begin
            part_rem <= trial[WIDTH-1:0];
            dvd_mag  <= {dvd_mag[WIDTH-2:0], 1'b1};
          end else begin
            part_rem <= shifted[WIDTH-1:0];
            dvd_mag  <= {dvd_mag[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
        end
        FIX: begin
          if (zero_div) begin
            quotient <= '1;
          end else begin
            quotient <= q_sign ? (~dvd_mag + 1'b1) : dvd_mag;
          end
          remainder   <= r_sign ? (~rem_src + 1'b1) : rem_src;
          div_by_zero <= zero_div;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner
// sequences (reset abort, held start) and back-to-back random operations.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        active;
  logic        div_by_zero;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .active     (active),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issues one op with a single-cycle start and returns clocks from E0 to the done pulse.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic logic [63:0] refDiv(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 0) begin
      q = -1;
      r = a;
    end else if (a == 32'sh80000000 && b == -1) begin
      q = 32'sh80000000;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  initial begin
    int          lat;
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] exp_qr;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    A        = '0;
    B        = '0;

    vecs[0]  = '{32'd200,        32'd20,         32'd10,         32'd0,          1'b0, 33};
    vecs[1]  = '{-32'sd7,        32'd2,          -32'sd3,        -32'sd1,        1'b0, 33};
    vecs[2]  = '{32'd7,          -32'sd2,        -32'sd3,        32'd1,          1'b0, 33};
    vecs[3]  = '{-32'sd7,        -32'sd2,        32'd3,          -32'sd1,        1'b0, 33};
    vecs[4]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vecs[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};
    vecs[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
    vecs[7]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33};
    vecs[8]  = '{32'h80000000,   32'd0,          32'hFFFFFFFF,   32'h80000000,   1'b1, 1};
    vecs[9]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[10] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};

    #12;
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_flags", {29'd0, done, active, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      checkOutput($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      checkOutput($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
      checkOutput($sformatf("vec%0d_active_at_done", i), {31'd0, active}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Reset mid-run: outputs clear at once and the aborted op never completes.
    @(negedge clk);
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("abort_active_running", {31'd0, active}, 32'd1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    checkOutput("abort_flags", {29'd0, done, active, div_by_zero}, 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, seen}, 32'd0);

    applyStimulus(32'd100, 32'd7, lat);
    checkOutput("restart_latency", lat, 33);
    checkOutput("restart_quotient", quotient, 32'd14);
    checkOutput("restart_remainder", remainder, 32'd2);

    // Start held high and operands changed mid-run must not disturb the op.
    @(negedge clk);
    A     = 32'd1000;
    B     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    A   = 32'd50;
    B   = 32'd5;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) checkOutput("held_quotient_stable", quotient, 32'd14);
      if (lat == 30) start = 1'b0;
    end
    start = 1'b0;
    checkOutput("held_latency", lat, 33);
    checkOutput("held_quotient", quotient, 32'd142);
    checkOutput("held_remainder", remainder, 32'd6);

    // Random pairs, each next op started in the done cycle of the previous one.
    ra = $urandom;
    rb = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) rb = -rb;
    @(negedge clk);
    A     = ra;
    B     = rb;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      exp_qr = refDiv(ra, rb);
      checkOutput($sformatf("rand%0d_latency", i), lat, (rb == 0) ? 1 : 33);
      checkOutput($sformatf("rand%0d_quotient", i), quotient, exp_qr[63:32]);
      checkOutput($sformatf("rand%0d_remainder", i), remainder, exp_qr[31:0]);
      if (i < 199) begin
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) rb = -rb;
        A     = ra;
        B     = rb;
        start = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rand_final_done_clear", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
